pc_event_fifo: RTL and testbench

PC_EVENT_FIFO -- requirements
Module: pc_event_fifo

---
 rtl/pc_event_fifo.sv | 107 ++++++++++
 tb/tb_pc_event_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_event_fifo.sv
// Event FIFO between the PC monitor and the LUT stage; full pushes are dropped and latched in a sticky flag.
// Optional saturating drop counter enabled by defining DIAGNOSIS_PC_FIFO_DROP_CNT_EN.
`ifndef DIAGNOSIS_EV_ID_WIDTH
`define DIAGNOSIS_EV_ID_WIDTH 8
`endif
`ifndef DIAGNOSIS_TIMESTAMP_WIDTH
`define DIAGNOSIS_TIMESTAMP_WIDTH 32
`endif

module pc_event_fifo #(
    parameter int EVENT_ID_WIDTH  = `DIAGNOSIS_EV_ID_WIDTH,
    parameter int TIMESTAMP_WIDTH = `DIAGNOSIS_TIMESTAMP_WIDTH,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       diag_sys_enabled,
    input  logic                       pc_ev_valid,
    input  logic [EVENT_ID_WIDTH-1:0]  pc_ev_id,
    input  logic [TIMESTAMP_WIDTH-1:0] pc_ev_time,
    output logic                       out_ev_valid,
    input  logic                       out_ev_ready,
    output logic [EVENT_ID_WIDTH-1:0]  out_ev_id,
    output logic [TIMESTAMP_WIDTH-1:0] out_ev_time,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
`ifdef DIAGNOSIS_PC_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = EVENT_ID_WIDTH + TIMESTAMP_WIDTH;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          overflow_reg;

    logic req;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        req  = pc_ev_valid & diag_sys_enabled;
        full = (level_reg == LW'(DEPTH));
        pop  = (level_reg != '0) & out_ev_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push = req & (~full | pop);
        drop = req & full & ~pop;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                level_reg <= level_reg + LW'(1);
            end else if (pop && !push) begin
                level_reg <= level_reg - LW'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {pc_ev_id, pc_ev_time};
        end
    end

    assign out_ev_valid               = (level_reg != '0);
    assign {out_ev_id, out_ev_time}   = mem[rd_ptr_reg];
    assign fifo_level                 = level_reg;
    assign overflow                   = overflow_reg;

`ifdef DIAGNOSIS_PC_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_reg <= '0;
        end else if (drop && drop_cnt_reg != 16'hFFFF) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_pc_event_fifo.sv
// Randomized and directed bench for pc_event_fifo against a queue-based reference model.
// Define DIAGNOSIS_PC_FIFO_DROP_CNT_EN to also exercise the drop counter.
module tb_pc_event_fifo;
    localparam int IW    = 8;
    localparam int TW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int DW    = IW + TW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          diag_sys_enabled = 1'b0;
    logic          pc_ev_valid = 1'b0;
    logic [IW-1:0] pc_ev_id = '0;
    logic [TW-1:0] pc_ev_time = '0;
    logic          out_ev_valid;
    logic          out_ev_ready = 1'b0;
    logic [IW-1:0] out_ev_id;
    logic [TW-1:0] out_ev_time;
    logic [LW-1:0] fifo_level;
    logic          overflow;
`ifdef DIAGNOSIS_PC_FIFO_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    pc_event_fifo #(
        .EVENT_ID_WIDTH(IW),
        .TIMESTAMP_WIDTH(TW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .diag_sys_enabled(diag_sys_enabled),
        .pc_ev_valid(pc_ev_valid),
        .pc_ev_id(pc_ev_id),
        .pc_ev_time(pc_ev_time),
        .out_ev_valid(out_ev_valid),
        .out_ev_ready(out_ev_ready),
        .out_ev_id(out_ev_id),
        .out_ev_time(out_ev_time),
        .fifo_level(fifo_level),
        .overflow(overflow)
`ifdef DIAGNOSIS_PC_FIFO_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: contents in order, sticky overflow, drop count.
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    int unsigned   m_drops = 0;
    logic          cmp_en = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, return at the next falling edge.
    task automatic cyc(input logic v, input logic [IW-1:0] id, input logic [TW-1:0] t,
                       input logic rdy, input logic en, input logic rn);
        logic do_pop;
        logic do_push;
        logic do_drop;
        pc_ev_valid      = v;
        pc_ev_id         = id;
        pc_ev_time       = t;
        out_ev_ready     = rdy;
        diag_sys_enabled = en;
        rst              = rn;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            do_pop  = (q.size() > 0) && rdy;
            do_push = v && en && ((q.size() < DEPTH) || do_pop);
            do_drop = v && en && (q.size() == DEPTH) && !do_pop;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({id, t});
            if (do_drop) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("level", 64'(fifo_level), 64'(q.size()));
            chk("valid", 64'(out_ev_valid), 64'(q.size() > 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (q.size() > 0) begin
                chk("head_id", 64'(out_ev_id), 64'(q[0][DW-1:TW]));
                chk("head_time", 64'(out_ev_time), 64'(q[0][TW-1:0]));
            end
`ifdef DIAGNOSIS_PC_FIFO_DROP_CNT_EN
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
`endif
        end
    end

    initial begin
        int npush;
        @(negedge clk);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_valid", 64'(out_ev_valid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        cmp_en = 1'b1;

        // In-order delivery with one-cycle latency.
        cyc(1, 8'd1, 16'h0101, 1, 1, 1);
        chk("ord_id1", 64'(out_ev_id), 64'd1);
        cyc(1, 8'd2, 16'h0202, 1, 1, 1);
        chk("ord_id2", 64'(out_ev_id), 64'd2);
        cyc(1, 8'd3, 16'h0303, 1, 1, 1);
        chk("ord_id3", 64'(out_ev_id), 64'd3);
        chk("ord_time3", 64'(out_ev_time), 64'h0303);
        cyc(0, 0, 0, 1, 1, 1);
        chk("ord_empty", 64'(fifo_level), 64'd0);
        chk("ord_ovf", 64'(overflow), 64'd0);

        // Back-pressure and overflow.
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, IW'(10 + i), TW'(16'h1000 + i), 0, 1, 1);
            if (i == 3) chk("bp_level4", 64'(fifo_level), 64'd4);
            if (i == 4) chk("bp_ovf5", 64'(overflow), 64'd1);
        end
        chk("bp_head", 64'(out_ev_id), 64'd10);
        chk("bp_level", 64'(fifo_level), 64'd4);
`ifdef DIAGNOSIS_PC_FIFO_DROP_CNT_EN
        chk("bp_drops", 64'(drop_cnt), 64'd2);
`endif
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain", 64'(out_ev_id), 64'(10 + k));
            cyc(0, 0, 0, 1, 1, 1);
        end

        // Push and pop together while full.
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, IW'(20 + i), TW'(i), 0, 1, 1);
        cyc(1, 8'd99, 16'h0099, 1, 1, 1);
        chk("full_pp_level", 64'(fifo_level), 64'd4);
        chk("full_pp_ovf", 64'(overflow), 64'd0);
        chk("full_pp_head", 64'(out_ev_id), 64'd21);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 1, 1, 1);
        chk("full_pp_new", 64'(out_ev_id), 64'd99);
        cyc(0, 0, 0, 1, 1, 1);

        // Enable gating: stored entries drain, new strobes ignored.
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, IW'(30 + i), TW'(i), 0, 1, 1);
        cyc(1, 8'd50, 16'h0050, 1, 0, 1);
        chk("en_head", 64'(out_ev_id), 64'd31);
        for (int i = 0; i < 3; i++) cyc(1, 8'd51, 16'h0051, 1, 0, 1);
        chk("en_level", 64'(fifo_level), 64'd0);
        chk("en_ovf", 64'(overflow), 64'd0);

        // Reset mid-operation.
        for (int i = 0; i < 5; i++) cyc(1, IW'(40 + i), TW'(i), 0, 1, 1);
        cyc(0, 0, 0, 1, 1, 1);
        chk("mr_level3", 64'(fifo_level), 64'd3);
        chk("mr_ovf1", 64'(overflow), 64'd1);
        cyc(1, 8'd60, 16'h0060, 1, 1, 0);
        chk("mr_level0", 64'(fifo_level), 64'd0);
        chk("mr_valid0", 64'(out_ev_valid), 64'd0);
        chk("mr_ovf0", 64'(overflow), 64'd0);
        cyc(1, 8'd77, 16'h0077, 0, 1, 1);
        chk("mr_level1", 64'(fifo_level), 64'd1);
        chk("mr_id", 64'(out_ev_id), 64'd77);

        // Random traffic: pointer wrap, drops, gating.
        npush = 0;
        while (npush < 1000) begin
            logic v;
            v = ($urandom_range(0, 9) < 7);
            if (v) npush++;
            cyc(v, IW'($urandom), TW'($urandom), logic'($urandom_range(0, 1)),
                ($urandom_range(0, 9) != 0), 1);
        end
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 1, 1, 1);
        chk("rnd_empty", 64'(fifo_level), 64'd0);

`ifdef DIAGNOSIS_PC_FIFO_DROP_CNT_EN
        // Saturate the drop counter.
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 65545; i++) cyc(1, IW'(i), TW'(i), 0, 1, 1);
        chk("sat_drops", 64'(drop_cnt), 64'hFFFF);
`endif

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
